// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Assembles four little-endian bytes into a 32-bit word and pulses word_valid
// in the cycle after the fourth byte is accepted.
module word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        last_byte_c,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [23:0] shift;
    logic [1:0]  cnt;

    assign last_byte_c = (cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (reset) begin
            shift      <= '0;
            cnt        <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                cnt <= '0;
            end else if (byte_valid) begin
                if (last_byte_c) begin
                    word       <= {byte_data, shift};
                    word_valid <= 1'b1;
                    cnt        <= '0;
                end else begin
                    // Oldest byte drifts toward bit 0 so it ends up as the LSB.
                    shift <= {byte_data, shift[23:8]};
                    cnt   <= cnt + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Receives framed host bytes, writes words into the instruction RAM and holds
// the core in reset until a frame with a matching checksum has been loaded.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned AW      = 7,
    parameter logic [7:0]  MAGIC   = MAGIC_DEFAULT,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned TW      = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          im_we,
    output logic [AW-1:0] im_waddr,
    output logic [31:0]   im_wdata,
    output logic          cpu_hold,
    output logic          done,
    output logic          err
);

    localparam int unsigned IW        = AW + 1;
    localparam int unsigned MAX_WORDS = 32'd1 << AW;

    state_t        state;
    logic [IW-1:0] widx;
    logic [IW-1:0] nwords;
    logic [7:0]    csum;
    logic [TW-1:0] tcnt;

    logic xfer_c;
    logic pk_valid_c;
    logic pk_clear_c;
    logic last_byte_c;
    logic timeout_c;
    logic n_bad_c;
    logic in_frame_c;

    assign xfer_c     = in_valid && in_ready;
    assign pk_valid_c = xfer_c && (state == DATA);
    assign pk_clear_c = xfer_c && (state == COUNT);
    assign in_frame_c = (state == COUNT) || (state == DATA) || (state == CSUM);
    assign timeout_c  = (TIMEOUT != 0) && (tcnt == TW'(TIMEOUT - 1));
    assign n_bad_c    = (in_data == 8'd0) || (32'(in_data) > MAX_WORDS);

    word_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .clear       (pk_clear_c),
        .byte_valid  (pk_valid_c),
        .byte_data   (in_data),
        .last_byte_c (last_byte_c),
        .word_valid  (im_we),
        .word        (im_wdata)
    );

    // Frame FSM, word index, checksum and inter-byte timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            im_waddr <= '0;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            widx     <= '0;
            nwords   <= '0;
            csum     <= '0;
            tcnt     <= '0;
        end else begin
            in_ready <= 1'b1;

            case (state)
                IDLE: begin
                    if (xfer_c && in_data == MAGIC) state <= COUNT;
                end
                COUNT: begin
                    if (xfer_c) begin
                        if (n_bad_c) begin
                            state <= ERR;
                            err   <= 1'b1;
                        end else begin
                            nwords <= IW'(in_data);
                            widx   <= '0;
                            csum   <= '0;
                            state  <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer_c) begin
                        csum <= csum ^ in_data;
                        if (last_byte_c) begin
                            im_waddr <= widx[AW-1:0];
                            widx     <= widx + 1'b1;
                            if (widx + 1'b1 == nwords) state <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (xfer_c) begin
                        if (in_data == csum) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                DONE, ERR: begin
                    if (xfer_c && in_data == MAGIC) begin
                        state    <= COUNT;
                        cpu_hold <= 1'b1;
                        done     <= 1'b0;
                        err      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            // A transfer always wins over an expiring timeout.
            if (!in_frame_c || xfer_c) begin
                tcnt <= '0;
            end else if (timeout_c) begin
                tcnt     <= '0;
                state    <= ERR;
                err      <= 1'b1;
                cpu_hold <= 1'b1;
            end else begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected RAM writes are queued as frames
// are driven and matched against im_we pulses.
module tb_imem_loader;

    localparam int unsigned AW      = 7;
    localparam int unsigned TIMEOUT = 8;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          im_we;
    logic [AW-1:0] im_waddr;
    logic [31:0]   im_wdata;
    logic          cpu_hold;
    logic          done;
    logic          err;

    int assertions = 0;
    int failures   = 0;
    int wr_count   = 0;

    wr_t         exp_q[$];
    logic [31:0] payload [0:127];

    imem_loader #(
        .AW      (AW),
        .MAGIC   (8'hA5),
        .TIMEOUT (TIMEOUT),
        .TW      (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .im_we    (im_we),
        .im_waddr (im_waddr),
        .im_wdata (im_wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Drive one byte; a write pulse can only appear right after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        wr_t e;
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (im_we === 1'b1) begin
            wr_count++;
            assertions++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got addr %0d data %h, expected no write", im_waddr, im_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({im_waddr, im_wdata} !== {e.addr, e.data}) begin
                    failures++;
                    $display("FAIL write: got addr %0d data %h, expected addr %0d data %h",
                             im_waddr, im_wdata, e.addr, e.data);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends a full frame from payload[0..n-1]; optional stall after a payload byte.
    task automatic send_frame(input int n, input bit bad, input int stall_at, input int stall_len);
        logic [7:0] cs;
        logic [7:0] b;
        bit         exp_err;
        int         idx;
        cs  = 8'h00;
        idx = 0;
        exp_err = (stall_len >= int'(TIMEOUT));
        send_byte(8'hA5);
        send_byte(8'(n));
        for (int w = 0; w < n; w++) begin
            for (int k = 0; k < 4; k++) begin
                b  = 8'(payload[w] >> (8 * k));
                cs = cs ^ b;
                if (k == 3) exp_q.push_back('{addr: AW'(w), data: payload[w]});
                send_byte(b);
                if (idx == stall_at) begin
                    idle(stall_len);
                    assertions++;
                    if (err !== exp_err) begin
                        failures++;
                        $display("FAIL stall_%0d_err: got %b expected %b", stall_len, err, exp_err);
                    end
                    if (exp_err) return;
                end
                idx++;
            end
        end
        send_byte(bad ? (cs ^ 8'h01) : cs);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        assertions++;
        if ({in_ready, im_we, im_waddr, im_wdata} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got ready %b we %b addr %0d data %h expected all zero",
                     in_ready, im_we, im_waddr, im_wdata);
        end
        assertions++;
        if ({cpu_hold, done, err} !== 3'b100) begin
            failures++;
            $display("FAIL reset_status: got hold/done/err %b expected 100", {cpu_hold, done, err});
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        assertions++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_basic;
        payload[0] = 32'h0000_0013;
        payload[1] = 32'h0010_0093;
        send_frame(2, 1'b0, -1, 0);
        assertions++;
        if ({done, cpu_hold, err} !== 3'b100) begin
            failures++;
            $display("FAIL basic_status: got done/hold/err %b expected 100", {done, cpu_hold, err});
        end
        assertions++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL basic_missing_writes: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic test_bad_csum;
        payload[0] = 32'h0000_0013;
        payload[1] = 32'h0010_0093;
        send_frame(2, 1'b1, -1, 0);
        assertions++;
        if ({done, cpu_hold, err} !== 3'b011) begin
            failures++;
            $display("FAIL bad_csum_status: got done/hold/err %b expected 011", {done, cpu_hold, err});
        end
        assertions++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL bad_csum_missing_writes: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic test_bad_count;
        send_byte(8'hA5);
        send_byte(8'h00);
        assertions++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL count_zero_err: got %b expected 1", err);
        end
        send_byte(8'hA5);
        assertions++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL restart_clears_err: got %b expected 0", err);
        end
        send_byte(8'h81);
        assertions++;
        if ({err, cpu_hold} !== 2'b11) begin
            failures++;
            $display("FAIL count_big_err: got err/hold %b expected 11", {err, cpu_hold});
        end
        payload[0] = 32'hCAFE_F00D;
        send_frame(1, 1'b0, -1, 0);
        assertions++;
        if ({done, err, exp_q.size() == 0} !== 3'b101) begin
            failures++;
            $display("FAIL count_recover: got done/err/drained %b expected 101", {done, err, exp_q.size() == 0});
        end
    endtask

    task automatic test_full;
        int start;
        for (int i = 0; i < 128; i++)
            payload[i] = {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)};
        start = wr_count;
        send_frame(128, 1'b0, -1, 0);
        assertions++;
        if (wr_count - start != 128) begin
            failures++;
            $display("FAIL full_write_count: got %0d expected 128", wr_count - start);
        end
        assertions++;
        if ({done, cpu_hold, exp_q.size() == 0} !== 3'b101) begin
            failures++;
            $display("FAIL full_status: got done/hold/drained %b expected 101", {done, cpu_hold, exp_q.size() == 0});
        end
    endtask

    task automatic test_timeout;
        payload[0] = 32'h1122_3344;
        payload[1] = 32'h5566_7788;
        send_frame(2, 1'b0, 1, int'(TIMEOUT) - 1);
        assertions++;
        if ({done, err} !== 2'b10) begin
            failures++;
            $display("FAIL stall_short_done: got done/err %b expected 10", {done, err});
        end
        send_frame(2, 1'b0, 1, int'(TIMEOUT));
        assertions++;
        if ({done, cpu_hold, exp_q.size() == 0} !== 3'b011) begin
            failures++;
            $display("FAIL stall_long_status: got done/hold/drained %b expected 011", {done, cpu_hold, exp_q.size() == 0});
        end
    endtask

    task automatic test_reset_midframe;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'hEF);
        send_byte(8'hBE);
        send_byte(8'hAD);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hDE;
        @(posedge clk);
        #1;
        assertions++;
        if ({in_ready, im_we, cpu_hold, done, err} !== 5'b00100) begin
            failures++;
            $display("FAIL midreset_outputs: got ready/we/hold/done/err %b expected 00100",
                     {in_ready, im_we, cpu_hold, done, err});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        reset    = 1'b0;
        assertions++;
        if (im_we !== 1'b0) begin
            failures++;
            $display("FAIL midreset_no_write: got %b expected 0", im_we);
        end
        idle(1);
        send_byte(8'h13);
        payload[0] = 32'h0000_0073;
        send_frame(1, 1'b0, -1, 0);
        assertions++;
        if ({done, cpu_hold, err, exp_q.size() == 0} !== 4'b1001) begin
            failures++;
            $display("FAIL midreset_reload: got done/hold/err/drained %b expected 1001",
                     {done, cpu_hold, err, exp_q.size() == 0});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_csum();
        test_bad_count();
        test_full();
        test_timeout();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
